// File: rtl/melody_sample_source.sv
// melody_sample_source
// Table-driven melody sequencer feeding a stereo DAC FIFO. Each note-table
// entry holds a square-wave half-period and a duration in CLOCK_50 cycles.
// A zero duration marks the end of the song, and a zero half-period is a rest.
// A free-running sample timer emits one stereo sample per SAMPLE_DIV clocks.
// The sample is written only when the FIFO reports space; otherwise a
// saturating drop counter records the lost sample.
module melody_sample_source #(
  parameter int NUM_NOTES  = 16,
  parameter int AMPLITUDE  = 100000000,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_addr,
  input  logic [19:0] tbl_half_period,
  input  logic [27:0] tbl_duration,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic [3:0]  note_idx,
  output logic        playing,
  output logic        song_wrap,
  output logic [15:0] drop_count
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
  localparam int CNT_W = $clog2(SAMPLE_DIV + 1);

  localparam logic [IDX_W-1:0] IDX_ZERO_C = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST_C = IDX_W'(NUM_NOTES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [31:0]      AMP_POS_C  = 32'(AMPLITUDE);
  localparam logic [31:0]      AMP_NEG_C  = 32'd0 - AMP_POS_C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  // Note table storage (not reset; contents are undefined until written)
  logic [19:0] hp_mem_r  [NUM_NOTES];
  logic [27:0] dur_mem_r [NUM_NOTES];

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] idx_r;
  logic [19:0]      hp_r;
  logic [27:0]      dur_r;
  logic [27:0]      beat_cnt_r;
  logic [19:0]      phase_cnt_r;
  logic             sign_r;
  logic             song_wrap_r;
  logic             playing_r;
  logic             playing_next_s;
  logic [CNT_W-1:0] sample_cnt_r;
  logic             tick_s;
  logic [31:0]      sample_s;
  logic             write_r;
  logic [31:0]      left_r;
  logic [31:0]      right_r;
  logic [15:0]      drop_r;

  logic [19:0]      tbl_hp_s;
  logic [27:0]      tbl_dur_s;
  logic             note_done_s;
  logic             phase_done_s;

  // The entry addressed by idx is read combinationally and latched during LOAD
  assign tbl_hp_s     = hp_mem_r[idx_r];
  assign tbl_dur_s    = dur_mem_r[idx_r];
  assign note_done_s  = (beat_cnt_r == (dur_r - 28'd1));
  assign phase_done_s = (phase_cnt_r == (hp_r - 20'd1));
  assign tick_s       = enable && (sample_cnt_r == CNT_LAST_C);

  // Note table write port; a rewrite of the playing entry is seen at its next LOAD
  always_ff @(posedge CLOCK_50) begin
    if (tbl_we) begin
      hp_mem_r[tbl_addr]  <= tbl_half_period;
      dur_mem_r[tbl_addr] <= tbl_duration;
    end
  end

  // Sequencer state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: enable low beats restart, and restart beats normal flow
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = ST_IDLE;
    end else if (restart) begin
      state_next_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_LOAD;
        end
        ST_LOAD: begin
          if (tbl_dur_s != 28'd0) begin
            state_next_s = ST_PLAY;
          end else if (idx_r == IDX_ZERO_C) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_LOAD;
          end
        end
        ST_PLAY: begin
          if (note_done_s) begin
            state_next_s = ST_LOAD;
          end else begin
            state_next_s = ST_PLAY;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: the square-wave sample and the next value of the playing flag
  always_comb begin
    sample_s       = 32'd0;
    playing_next_s = 1'b0;
    if ((state_r == ST_PLAY) && (hp_r != 20'd0)) begin
      if (sign_r) begin
        sample_s = AMP_NEG_C;
      end else begin
        sample_s = AMP_POS_C;
      end
    end else begin
      sample_s = 32'd0;
    end
    if (state_next_s == ST_PLAY) begin
      playing_next_s = 1'b1;
    end else begin
      playing_next_s = 1'b0;
    end
  end

  // Sequencer datapath: note index, latched note, beat/phase counters and wave sign
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      idx_r       <= IDX_ZERO_C;
      hp_r        <= 20'd0;
      dur_r       <= 28'd0;
      beat_cnt_r  <= 28'd0;
      phase_cnt_r <= 20'd0;
      sign_r      <= 1'b0;
      song_wrap_r <= 1'b0;
      playing_r   <= 1'b0;
    end else begin
      song_wrap_r <= 1'b0;
      playing_r   <= playing_next_s;
      if (!enable || restart) begin
        idx_r <= IDX_ZERO_C;
      end else begin
        case (state_r)
          ST_IDLE: begin
            idx_r <= IDX_ZERO_C;
          end
          ST_LOAD: begin
            hp_r  <= tbl_hp_s;
            dur_r <= tbl_dur_s;
            if (tbl_dur_s == 28'd0) begin
              // End-of-song marker: rewind, unless the song is empty
              if (idx_r != IDX_ZERO_C) begin
                idx_r       <= IDX_ZERO_C;
                song_wrap_r <= 1'b1;
              end
            end else begin
              beat_cnt_r  <= 28'd0;
              phase_cnt_r <= 20'd0;
              sign_r      <= 1'b0;
            end
          end
          ST_PLAY: begin
            beat_cnt_r <= beat_cnt_r + 28'd1;
            if (hp_r == 20'd0) begin
              phase_cnt_r <= 20'd0;
              sign_r      <= 1'b0;
            end else if (phase_done_s) begin
              phase_cnt_r <= 20'd0;
              sign_r      <= ~sign_r;
            end else begin
              phase_cnt_r <= phase_cnt_r + 20'd1;
            end
            if (note_done_s) begin
              if (idx_r == IDX_LAST_C) begin
                idx_r       <= IDX_ZERO_C;
                song_wrap_r <= 1'b1;
              end else begin
                idx_r <= idx_r + IDX_W'(1);
              end
            end
          end
          default: begin
            idx_r <= IDX_ZERO_C;
          end
        endcase
      end
    end
  end

  // Sample-period timer; it keeps running in IDLE and LOAD so silence is still streamed
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sample_cnt_r <= CNT_ZERO_C;
    end else if (!enable) begin
      sample_cnt_r <= CNT_ZERO_C;
    end else if (sample_cnt_r == CNT_LAST_C) begin
      sample_cnt_r <= CNT_ZERO_C;
    end else begin
      sample_cnt_r <= sample_cnt_r + CNT_W'(1);
    end
  end

  // Output sample register, write strobe and saturating drop counter
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      write_r <= 1'b0;
      left_r  <= 32'd0;
      right_r <= 32'd0;
      drop_r  <= 16'd0;
    end else begin
      write_r <= 1'b0;
      if (!enable) begin
        // Disabled player presents silence on both channels
        left_r  <= 32'd0;
        right_r <= 32'd0;
      end else if (tick_s) begin
        if (audio_out_allowed) begin
          write_r <= 1'b1;
          left_r  <= sample_s;
          right_r <= sample_s;
        end else if (drop_r != 16'hFFFF) begin
          drop_r <= drop_r + 16'd1;
        end
      end
    end
  end

  assign write_audio_out         = write_r;
  assign left_channel_audio_out  = left_r;
  assign right_channel_audio_out = right_r;
  assign note_idx                = 4'(idx_r);
  assign playing                 = playing_r;
  assign song_wrap               = song_wrap_r;
  assign drop_count              = drop_r;

endmodule

// File: tb/tb_melody_sample_source.sv
// Directed testbench for melody_sample_source (SAMPLE_DIV=4, AMPLITUDE=1000).
// A second instance with SAMPLE_DIV=1 is used to reach drop_count saturation quickly.
module tb_melody_sample_source;

  localparam logic [31:0] POS_C = 32'd1000;
  localparam logic [31:0] NEG_C = 32'hFFFF_FC18;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = 4'd0;
  logic [19:0] tbl_half_period = 20'd0;
  logic [27:0] tbl_duration = 28'd0;
  logic        audio_out_allowed = 1'b1;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;
  logic [3:0]  note_idx;
  logic        playing;
  logic        song_wrap;
  logic [15:0] drop_count;

  logic        enable_fast = 1'b0;
  logic        f_write;
  logic [31:0] f_left;
  logic [31:0] f_right;
  logic [3:0]  f_idx;
  logic        f_playing;
  logic        f_wrap;
  logic [15:0] f_drop;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  melody_sample_source #(.NUM_NOTES(16), .AMPLITUDE(1000), .SAMPLE_DIV(4)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .restart(restart),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_half_period(tbl_half_period),
    .tbl_duration(tbl_duration), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out), .note_idx(note_idx),
    .playing(playing), .song_wrap(song_wrap), .drop_count(drop_count)
  );

  melody_sample_source #(.NUM_NOTES(16), .AMPLITUDE(1000), .SAMPLE_DIV(1)) u_fast (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable_fast), .restart(1'b0),
    .tbl_we(1'b0), .tbl_addr(4'd0), .tbl_half_period(20'd0),
    .tbl_duration(28'd0), .audio_out_allowed(1'b0),
    .write_audio_out(f_write), .left_channel_audio_out(f_left),
    .right_channel_audio_out(f_right), .note_idx(f_idx),
    .playing(f_playing), .song_wrap(f_wrap), .drop_count(f_drop)
  );

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    restart = 1'b0;
    tbl_we = 1'b0;
    audio_out_allowed = 1'b1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  task automatic wr_entry(input logic [3:0] a, input logic [19:0] hp, input logic [27:0] dur);
    tbl_we = 1'b1;
    tbl_addr = a;
    tbl_half_period = hp;
    tbl_duration = dur;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({write_audio_out, left_channel_audio_out, right_channel_audio_out, note_idx,
         playing, song_wrap, drop_count} !== 87'd0) begin
      errors++;
      $display("FAIL reset_outputs: got w=%0b l=%h idx=%0d p=%0b sw=%0b d=%0d expected all 0",
               write_audio_out, left_channel_audio_out, note_idx, playing, song_wrap, drop_count);
    end
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({write_audio_out, playing, note_idx} !== 6'd0) begin
      errors++;
      $display("FAIL idle_disabled: got w=%0b p=%0b idx=%0d expected 0", write_audio_out, playing, note_idx);
    end
  endtask

  task automatic test_basic_note();
    int strobes;
    int wraps;
    do_reset();
    wr_entry(4'd0, 20'd3, 28'd12);
    wr_entry(4'd1, 20'd0, 28'd0);
    strobes = 0;
    wraps = 0;
    enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (write_audio_out === 1'b1) strobes++;
      if (song_wrap === 1'b1) wraps++;
      case (c)
        2: begin
          checks++;
          if (playing !== 1'b1) begin errors++; $display("FAIL basic_play_start: got %0b expected 1", playing); end
        end
        4: begin
          checks++;
          if ({write_audio_out, left_channel_audio_out, right_channel_audio_out} !== {1'b1, POS_C, POS_C}) begin
            errors++;
            $display("FAIL basic_first_sample: got w=%0b l=%h r=%h expected w=1 l=r=%h",
                     write_audio_out, left_channel_audio_out, right_channel_audio_out, POS_C);
          end
        end
        5: begin
          checks++;
          if (write_audio_out !== 1'b0) begin errors++; $display("FAIL basic_strobe_width: got %0b expected 0", write_audio_out); end
        end
        8, 12, 20: begin
          checks++;
          if ({write_audio_out, left_channel_audio_out} !== {1'b1, NEG_C}) begin
            errors++;
            $display("FAIL basic_neg_sample_c%0d: got w=%0b l=%h expected w=1 l=%h",
                     c, write_audio_out, left_channel_audio_out, NEG_C);
          end
        end
        14: begin
          checks++;
          if ({playing, note_idx} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL basic_note_end: got p=%0b idx=%0d expected p=0 idx=1", playing, note_idx);
          end
        end
        15: begin
          checks++;
          if ({song_wrap, note_idx, playing} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL basic_wrap: got sw=%0b idx=%0d p=%0b expected sw=1 idx=0 p=0", song_wrap, note_idx, playing);
          end
        end
        16: begin
          checks++;
          if ({song_wrap, playing, write_audio_out, left_channel_audio_out} !== {1'b0, 1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL basic_replay: got sw=%0b p=%0b w=%0b l=%h expected sw=0 p=1 w=1 l=0",
                     song_wrap, playing, write_audio_out, left_channel_audio_out);
          end
        end
        default: ;
      endcase
    end
    checks++;
    if (strobes !== 5) begin errors++; $display("FAIL basic_strobe_count: got %0d expected 5", strobes); end
    checks++;
    if (wraps !== 1) begin errors++; $display("FAIL basic_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_rest_and_empty();
    int strobes;
    int play_cycles;
    int nonzero;
    do_reset();
    wr_entry(4'd0, 20'd0, 28'd8);
    wr_entry(4'd1, 20'd0, 28'd0);
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if ({write_audio_out, playing, left_channel_audio_out} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL rest_sample: got w=%0b p=%0b l=%h expected w=1 p=1 l=0",
               write_audio_out, playing, left_channel_audio_out);
    end
    enable = 1'b0;
    step();
    wr_entry(4'd0, 20'd5, 28'd0);
    enable = 1'b1;
    strobes = 0;
    play_cycles = 0;
    nonzero = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (playing !== 1'b0) play_cycles++;
      if (write_audio_out === 1'b1) begin
        strobes++;
        if (left_channel_audio_out !== 32'd0) nonzero++;
      end
    end
    checks++;
    if (play_cycles !== 0) begin errors++; $display("FAIL empty_playing: got %0d cycles expected 0", play_cycles); end
    checks++;
    if (strobes !== 3) begin errors++; $display("FAIL empty_strobes: got %0d expected 3", strobes); end
    checks++;
    if (nonzero !== 0) begin errors++; $display("FAIL empty_silence: got %0d nonzero samples expected 0", nonzero); end
  endtask

  task automatic test_backpressure();
    int strobes;
    do_reset();
    wr_entry(4'd0, 20'd3, 28'd12);
    wr_entry(4'd1, 20'd0, 28'd0);
    audio_out_allowed = 1'b0;
    enable = 1'b1;
    strobes = 0;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (write_audio_out === 1'b1) strobes++;
      if (c == 40) begin
        checks++;
        if (drop_count !== 16'd10) begin errors++; $display("FAIL bp_drop_mid: got %0d expected 10", drop_count); end
      end
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL bp_no_strobe: got %0d expected 0", strobes); end
    checks++;
    if (drop_count !== 16'd20) begin errors++; $display("FAIL bp_drop_20: got %0d expected 20", drop_count); end
    audio_out_allowed = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if ({write_audio_out, drop_count} !== {1'b1, 16'd20}) begin
      errors++;
      $display("FAIL bp_resume: got w=%0b d=%0d expected w=1 d=20", write_audio_out, drop_count);
    end
  endtask

  task automatic test_full_wrap();
    int first_wrap;
    int second_wrap;
    int wraps;
    do_reset();
    for (int k = 0; k < 16; k++) wr_entry(4'(k), 20'd2, 28'd5);
    first_wrap = -1;
    second_wrap = -1;
    wraps = 0;
    enable = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (song_wrap === 1'b1) begin
        wraps++;
        if (first_wrap < 0) first_wrap = c;
        else if (second_wrap < 0) second_wrap = c;
      end
      if ((c >= 2) && (((c - 2) % 6) == 0) && (((c - 2) / 6) < 16)) begin
        checks++;
        if ({playing, note_idx} !== {1'b1, 4'((c - 2) / 6)}) begin
          errors++;
          $display("FAIL wrap_idx_step_c%0d: got p=%0b idx=%0d expected p=1 idx=%0d", c, playing, note_idx, (c - 2) / 6);
        end
      end
      if (c == 98) begin
        checks++;
        if ({song_wrap, playing, note_idx} !== {1'b0, 1'b1, 4'd0}) begin
          errors++;
          $display("FAIL wrap_replay: got sw=%0b p=%0b idx=%0d expected sw=0 p=1 idx=0", song_wrap, playing, note_idx);
        end
      end
    end
    checks++;
    if (first_wrap !== 97) begin errors++; $display("FAIL wrap_first: got cycle %0d expected 97", first_wrap); end
    checks++;
    if (second_wrap - first_wrap !== 96) begin
      errors++;
      $display("FAIL wrap_period: got %0d expected 96", second_wrap - first_wrap);
    end
    checks++;
    if (wraps !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", wraps); end
  endtask

  task automatic test_control_priority();
    int strobes;
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      step();
      case (c)
        20: begin
          checks++;
          if ({playing, note_idx} !== {1'b1, 4'd3}) begin
            errors++;
            $display("FAIL prio_at_idx3: got p=%0b idx=%0d expected p=1 idx=3", playing, note_idx);
          end
        end
        22: begin
          checks++;
          if ({playing, note_idx} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL prio_restart_load: got p=%0b idx=%0d expected p=0 idx=0", playing, note_idx);
          end
        end
        23: begin
          checks++;
          if ({playing, note_idx} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL prio_restart_play: got p=%0b idx=%0d expected p=1 idx=0", playing, note_idx);
          end
        end
        28: begin
          checks++;
          if ({write_audio_out, left_channel_audio_out} !== {1'b1, POS_C}) begin
            errors++;
            $display("FAIL prio_sample: got w=%0b l=%h expected w=1 l=%h", write_audio_out, left_channel_audio_out, POS_C);
          end
        end
        29: begin
          checks++;
          if ({playing, note_idx} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL prio_next_note: got p=%0b idx=%0d expected p=1 idx=1", playing, note_idx);
          end
        end
        default: ;
      endcase
      if (c == 21) restart = 1'b1;
      else restart = 1'b0;
    end
    enable = 1'b0;
    step();
    checks++;
    if ({playing, note_idx, write_audio_out, left_channel_audio_out, right_channel_audio_out} !== 70'd0) begin
      errors++;
      $display("FAIL prio_disable: got p=%0b idx=%0d w=%0b l=%h r=%h expected all 0",
               playing, note_idx, write_audio_out, left_channel_audio_out, right_channel_audio_out);
    end
    strobes = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (write_audio_out === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL prio_disable_strobes: got %0d expected 0", strobes); end

    enable = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if ({write_audio_out, left_channel_audio_out} !== {1'b1, POS_C}) begin
      errors++;
      $display("FAIL prio_pre_reset: got w=%0b l=%h expected w=1 l=%h", write_audio_out, left_channel_audio_out, POS_C);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({write_audio_out, left_channel_audio_out, right_channel_audio_out, note_idx,
         playing, song_wrap, drop_count} !== 87'd0) begin
      errors++;
      $display("FAIL prio_async_reset: got w=%0b l=%h p=%0b idx=%0d expected all 0",
               write_audio_out, left_channel_audio_out, playing, note_idx);
    end
    enable = 1'b0;
    #1;
    reset = 1'b0;
    step();
  endtask

  task automatic test_drop_saturation();
    do_reset();
    enable_fast = 1'b1;
    for (int c = 1; c <= 65534; c++) step();
    checks++;
    if (f_drop !== 16'hFFFE) begin errors++; $display("FAIL sat_before: got %h expected fffe", f_drop); end
    step();
    checks++;
    if (f_drop !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", f_drop); end
    for (int c = 1; c <= 10; c++) step();
    checks++;
    if (f_drop !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", f_drop); end
    enable_fast = 1'b0;
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_basic_note();
    test_rest_and_empty();
    test_backpressure();
    test_full_wrap();
    test_control_priority();
    test_drop_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
